// File: rtl/boreal_eeg_scan_sequencer_if.sv
// Shared single-conversion ADC handshake between the scan
// sequencer (master) and the converter front end (slave).
interface boreal_eeg_scan_sequencer_if;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_done;
  logic [23:0] adc_data;

  modport master (
    output adc_start,
    output adc_ch,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  adc_start,
    input  adc_ch,
    output adc_done,
    output adc_data
  );
endinterface

// File: rtl/boreal_eeg_scan_sequencer.sv
// Frame-paced 8-channel EEG scan sequencer: divider tick starts a
// frame, enabled channels convert in turn, frame emitted as one block.
module boreal_eeg_scan_sequencer #(
  parameter int CLK_DIV = 1000,
  parameter int TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [7:0]                         ch_mask,
  boreal_eeg_scan_sequencer_if.master        adc,
  output logic [191:0]                       raw_eeg_array,
  output logic                               data_valid,
  output logic                               busy,
  output logic [7:0]                         fault_mask,
  output logic [7:0]                         overrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EMIT  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        mask_q, mask_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [7:0][23:0]  buf_q, buf_d;
  logic [7:0][23:0]  raw_q, raw_d;
  logic [7:0]        fault_q, fault_d;
  logic [7:0]        ovr_q, ovr_d;

  logic              tick;
  logic              adv;
  logic [3:0]        first_ch;
  logic [3:0]        next_ch;

  // Lowest enabled channel at or above lo; bit 3 flags a hit.
  function automatic logic [3:0] pick_ch(
    input logic [7:0] m,
    input logic [3:0] lo
  );
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (4'(i) >= lo)) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  assign tick     = enable && (cnt_q == DIV_LAST);
  assign first_ch = pick_ch(ch_mask, 4'd0);
  assign next_ch  = pick_ch(mask_q, {1'b0, ptr_q} + 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    tmo_d   = tmo_q;
    buf_d   = buf_q;
    raw_d   = raw_q;
    fault_d = fault_q;
    ovr_d   = ovr_q;
    adv     = 1'b0;

    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end

    // A tick that lands while a frame is still scanning is lost.
    if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (tick && (ch_mask != 8'h00)) begin
          mask_d  = ch_mask;
          ptr_d   = first_ch[2:0];
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (adc.adc_done) begin
          buf_d[ptr_q]   = adc.adc_data;
          fault_d[ptr_q] = 1'b0;
          adv            = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          fault_d[ptr_q] = 1'b1;
          adv            = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (adv) begin
          if (next_ch[3]) begin
            ptr_d   = next_ch[2:0];
            state_d = S_START;
          end else begin
            raw_d   = buf_d;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= '0;
      raw_q   <= '0;
      fault_q <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      buf_q   <= buf_d;
      raw_q   <= raw_d;
      fault_q <= fault_d;
      ovr_q   <= ovr_d;
    end
  end

  assign adc.adc_start = (state_q == S_START);
  assign adc.adc_ch    = ptr_q;
  assign raw_eeg_array = raw_q;
  assign data_valid    = (state_q == S_EMIT);
  assign busy          = (state_q != S_IDLE);
  assign fault_mask    = fault_q;
  assign overrun_cnt   = ovr_q;

endmodule
